// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register index, forward-select encoding,
// shadow slot contents, and the slot match / forward-pick helpers.
package hazard_scoreboard_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    regbits_t rs;
    regbits_t rt;
    regbits_t dest;
    logic     regwen;
    logic     memread;
  } sb_entry_t;

  // $0 is hard-wired to zero, so it can never be the subject of a hazard or a bypass.
  function automatic logic slot_match(input sb_entry_t slot, input regbits_t r);
    return slot.valid && slot.regwen && (slot.dest == r) && (r != '0);
  endfunction

  // MEM result is the newest, but a load in MEM has no data yet.
  function automatic fwd_sel_t fwd_pick(input sb_entry_t mem, input sb_entry_t wb,
                                        input regbits_t src);
    if (slot_match(mem, src) && !mem.memread) return FWD_EXMEM;
    if (slot_match(wb, src)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_slot.sv
// One shadow pipeline latch: async clear, synchronous flush (wins over enable), load enable.
module sb_slot
  import hazard_scoreboard_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      flush,
  input  logic      en,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow EX/MEM/WB destination tracking: RAW stall request, EX forwarding selects,
// and a saturating count of stall cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic [4:0]       idDest,
  input  logic             idRegWEN,
  input  logic             idMemRead,
  input  logic             idW,
  input  logic             exW,
  input  logic             memW,
  input  logic             idRST,
  input  logic             exRST,
  input  logic             memRST,
  input  logic             cnt_clr,
  output logic             data_hazard,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t id_entry, ex_q, mem_q, wb_q;
  logic      rs_ex, rt_ex, rs_mem, rt_mem;
  logic      unused_ok;

  assign id_entry = '{valid: 1'b1, rs: idRs, rt: idRt, dest: idDest,
                      regwen: idRegWEN, memread: idMemRead};

  sb_slot u_ex (
    .CLK(CLK), .nRST(nRST), .flush(idRST), .en(idW), .d(id_entry), .q(ex_q)
  );
  sb_slot u_mem (
    .CLK(CLK), .nRST(nRST), .flush(exRST), .en(exW), .d(ex_q), .q(mem_q)
  );
  sb_slot u_wb (
    .CLK(CLK), .nRST(nRST), .flush(memRST), .en(memW), .d(mem_q), .q(wb_q)
  );

  always_comb begin
    rs_ex  = idUsesRs && slot_match(ex_q, idRs);
    rt_ex  = idUsesRt && slot_match(ex_q, idRt);
    rs_mem = idUsesRs && slot_match(mem_q, idRs);
    rt_mem = idUsesRt && slot_match(mem_q, idRt);
    if (FWD_EN) begin
      data_hazard = (rs_ex || rt_ex) && ex_q.memread;
    end else begin
      // WB is ignored: the register file writes in the first half-cycle.
      data_hazard = rs_ex || rt_ex || rs_mem || rt_mem;
    end
  end

  assign fwdA = FWD_EN ? fwd_pick(mem_q, wb_q, ex_q.rs) : FWD_RF;
  assign fwdB = FWD_EN ? fwd_pick(mem_q, wb_q, ex_q.rt) : FWD_RF;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (data_hazard && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign unused_ok = ^{mem_q.rs, mem_q.rt, wb_q.rs, wb_q.rt, wb_q.memread};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic checked
// against a behavioural model of the three shadow pipeline stages.
module tb_hazard_scoreboard;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [4:0] idRs, idRt, idDest;
  logic       idUsesRs, idUsesRt, idRegWEN, idMemRead;
  logic       idW, exW, memW, idRST, exRST, memRST, cnt_clr;
  logic       h1, h0;
  logic [1:0] fa1, fb1, fa0, fb0;
  logic [15:0] c1;
  logic [4:0]  c0;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  hazard_scoreboard #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .CLK(CLK), .nRST(nRST), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
    .idUsesRt(idUsesRt), .idDest(idDest), .idRegWEN(idRegWEN), .idMemRead(idMemRead),
    .idW(idW), .exW(exW), .memW(memW), .idRST(idRST), .exRST(exRST), .memRST(memRST),
    .cnt_clr(cnt_clr), .data_hazard(h1), .fwdA(fa1), .fwdB(fb1), .stall_cnt(c1)
  );

  hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(5)) u_nofwd (
    .CLK(CLK), .nRST(nRST), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
    .idUsesRt(idUsesRt), .idDest(idDest), .idRegWEN(idRegWEN), .idMemRead(idMemRead),
    .idW(idW), .exW(exW), .memW(memW), .idRST(idRST), .exRST(exRST), .memRST(memRST),
    .cnt_clr(cnt_clr), .data_hazard(h0), .fwdA(fa0), .fwdB(fb0), .stall_cnt(c0)
  );

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit valid;
    int rs, rt, dest;
    bit wen, mr;
  } ref_slot_t;

  ref_slot_t m[3];
  int mc1, mc0;

  function automatic bit m_match(int s, int r);
    return m[s].valid && m[s].wen && m[s].dest == r && r != 0;
  endfunction

  function automatic bit m_haz(bit fwd_en);
    bit a_ex, b_ex, a_mem, b_mem;
    a_ex  = idUsesRs && m_match(0, int'(idRs));
    b_ex  = idUsesRt && m_match(0, int'(idRt));
    a_mem = idUsesRs && m_match(1, int'(idRs));
    b_mem = idUsesRt && m_match(1, int'(idRt));
    if (fwd_en) return (a_ex || b_ex) && m[0].mr;
    return a_ex || b_ex || a_mem || b_mem;
  endfunction

  function automatic int m_fwd(int src);
    if (m_match(1, src) && !m[1].mr) return 1;
    if (m_match(2, src)) return 2;
    return 0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, 0};
    mc1 = 0;
    mc0 = 0;
  endtask

  task automatic tick();
    bit hz1, hz0;
    ref_slot_t fresh;
    hz1 = m_haz(1'b1);
    hz0 = m_haz(1'b0);
    fresh = '{1, int'(idRs), int'(idRt), int'(idDest), idRegWEN, idMemRead};
    @(posedge CLK);
    if (!nRST) begin
      m_clear();
    end else begin
      if (memRST) m[2] = '{0, 0, 0, 0, 0, 0}; else if (memW) m[2] = m[1];
      if (exRST)  m[1] = '{0, 0, 0, 0, 0, 0}; else if (exW)  m[1] = m[0];
      if (idRST)  m[0] = '{0, 0, 0, 0, 0, 0}; else if (idW)  m[0] = fresh;
      if (cnt_clr) mc1 = 0; else if (hz1 && mc1 < 65535) mc1++;
      if (cnt_clr) mc0 = 0; else if (hz0 && mc0 < 31) mc0++;
    end
    @(negedge CLK);
  endtask

  task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit wen, input bit mr);
    idRs = 5'(rs); idRt = 5'(rt); idUsesRs = urs; idUsesRt = urt;
    idDest = 5'(dest); idRegWEN = wen; idMemRead = mr;
  endtask

  task automatic set_ctl(input bit iw, input bit ew, input bit mw,
                         input bit ir, input bit er, input bit mrst);
    idW = iw; exW = ew; memW = mw; idRST = ir; exRST = er; memRST = mrst;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    m_clear();
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_ctl(1, 1, 1, 0, 0, 0);
    cnt_clr = 1'b0;
    do_reset();
    total++; if (h1 !== 1'b0) begin bad++; $display("FAIL reset_haz got=%0b exp=0", h1); end
    total++; if ({fa1, fb1} !== 4'b0) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {fa1, fb1}); end
    total++; if (c1 !== 16'd0 || c0 !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", c1, c0); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0);
    set_id(1, 2, 1, 0, 2, 1, 1);         // lw $2, 0($1)
    tick();
    set_id(2, 4, 1, 1, 3, 1, 0);         // add $3, $2, $4
    #1;
    total++; if (h1 !== 1'b1) begin bad++; $display("FAIL load_use_haz got=%0b exp=1", h1); end
    set_ctl(0, 1, 1, 1, 0, 0);           // bubble into EX, hold ID
    tick();
    total++; if (c1 !== 16'd1) begin bad++; $display("FAIL load_use_cnt got=%0d exp=1", c1); end
    total++; if (h1 !== 1'b0) begin bad++; $display("FAIL load_use_after_bubble got=%0b exp=0", h1); end
    set_ctl(1, 1, 1, 0, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (fa1 !== 2'b10 || fb1 !== 2'b00) begin bad++; $display("FAIL load_use_fwd got=%b/%b exp=10/00", fa1, fb1); end
    total++; if (fa0 !== 2'b00 || fb0 !== 2'b00) begin bad++; $display("FAIL nofwd_sel got=%b/%b exp=00/00", fa0, fb0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0);
    set_id(1, 1, 1, 1, 5, 1, 0);         // add $5, $1, $1
    tick();
    set_id(5, 5, 1, 1, 6, 1, 0);         // sub $6, $5, $5
    #1;
    total++; if (h1 !== 1'b0) begin bad++; $display("FAIL b2b_haz got=%0b exp=0", h1); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (fa1 !== 2'b01 || fb1 !== 2'b01) begin bad++; $display("FAIL b2b_fwd got=%b/%b exp=01/01", fa1, fb1); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0);
    set_id(1, 0, 1, 0, 0, 1, 1);         // lw $0
    tick();
    set_id(0, 0, 1, 1, 4, 1, 0);         // reader of $0
    #1;
    total++; if (h1 !== 1'b0 || h0 !== 1'b0) begin bad++; $display("FAIL zero_haz got=%0b/%0b exp=0/0", h1, h0); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (fa1 !== 2'b00 || fb1 !== 2'b00) begin bad++; $display("FAIL zero_fwd got=%b/%b exp=00/00", fa1, fb1); end
  endtask

  task automatic test_mem_priority();
    for (int ld = 0; ld < 2; ld++) begin
      do_reset();
      set_ctl(1, 1, 1, 0, 0, 0);
      set_id(1, 1, 1, 1, 7, 1, 0);       // older producer of $7
      tick();
      set_id(1, 1, 1, 1, 7, 1, ld[0]);   // newer producer of $7 (load on 2nd pass)
      tick();
      set_id(7, 7, 1, 1, 9, 1, 0);       // consumer
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0);
      #1;
      if (ld == 0) begin
        total++; if (fa1 !== 2'b01 || fb1 !== 2'b01) begin bad++; $display("FAIL mem_wins got=%b/%b exp=01/01", fa1, fb1); end
      end else begin
        total++; if (fa1 !== 2'b10 || fb1 !== 2'b10) begin bad++; $display("FAIL mem_load_skip got=%b/%b exp=10/10", fa1, fb1); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0);
    set_id(1, 0, 1, 0, 2, 1, 1);         // lw $2 into EX
    tick();
    set_ctl(1, 0, 0, 1, 0, 0);           // flush and write on same edge
    tick();
    set_ctl(0, 0, 0, 0, 0, 0);
    set_id(2, 0, 1, 0, 3, 1, 0);
    #1;
    total++; if (h1 !== 1'b0) begin bad++; $display("FAIL id_rst_wins got=%0b exp=0", h1); end
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0);
    set_id(0, 0, 1, 0, 9, 1, 0);         // addi $9 into EX
    tick();
    set_ctl(0, 1, 0, 1, 1, 0);           // exRST with valid EX, EX also flushed
    tick();
    set_ctl(0, 0, 0, 0, 0, 0);
    set_id(9, 0, 1, 0, 4, 1, 0);
    #1;
    total++; if (h0 !== 1'b0) begin bad++; $display("FAIL ex_rst_mem got=%0b exp=0", h0); end
  endtask

  task automatic test_nofwd_stall();
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0);
    set_id(0, 0, 1, 0, 8, 1, 0);         // addi $8, $0
    tick();
    set_id(8, 0, 1, 1, 9, 1, 0);         // or $9, $8, $0
    #1;
    total++; if (h0 !== 1'b1 || h1 !== 1'b0) begin bad++; $display("FAIL nofwd_ex got=%0b/%0b exp=1/0", h0, h1); end
    set_ctl(0, 1, 1, 1, 0, 0);
    tick();
    total++; if (h0 !== 1'b1) begin bad++; $display("FAIL nofwd_mem got=%0b exp=1", h0); end
    tick();
    total++; if (h0 !== 1'b0 || c0 !== 5'd2) begin bad++; $display("FAIL nofwd_done got=%0b cnt=%0d exp=0 cnt=2", h0, c0); end
    set_ctl(1, 1, 1, 0, 0, 0);
    tick();                              // or $9 enters EX
    set_id(9, 0, 1, 0, 10, 1, 0);
    #1;
    total++; if (h0 !== 1'b1) begin bad++; $display("FAIL nofwd_second got=%0b exp=1", h0); end
    nRST = 1'b0;                         // asynchronous reset, no clock edge
    #1;
    m_clear();
    total++; if (h0 !== 1'b0 || c0 !== 5'd0) begin bad++; $display("FAIL async_rst got=%0b cnt=%0d exp=0 cnt=0", h0, c0); end
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0);
    set_id(0, 0, 1, 0, 8, 1, 1);         // lw $8 into EX
    tick();
    set_ctl(0, 0, 0, 0, 0, 0);
    set_id(8, 0, 1, 0, 9, 1, 0);
    for (int i = 0; i < 37; i++) tick();
    total++; if (c0 !== 5'd31) begin bad++; $display("FAIL sat_cnt got=%0d exp=31", c0); end
    total++; if (c1 !== 16'd37) begin bad++; $display("FAIL count37 got=%0d exp=37", c1); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    total++; if (c0 !== 5'd0 || c1 !== 16'd0) begin bad++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", c1, c0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      set_ctl(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      cnt_clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 60) == 0) begin
        nRST = 1'b0;
        #1;
        m_clear();
        nRST = 1'b1;
      end
      #1;
      total++; if (h1 !== m_haz(1'b1)) begin bad++; $display("FAIL rnd_haz_fwd n=%0d got=%0b exp=%0b", n, h1, m_haz(1'b1)); end
      total++; if (h0 !== m_haz(1'b0)) begin bad++; $display("FAIL rnd_haz_nofwd n=%0d got=%0b exp=%0b", n, h0, m_haz(1'b0)); end
      total++; if (int'(fa1) != m_fwd(m[0].rs) || int'(fb1) != m_fwd(m[0].rt)) begin bad++; $display("FAIL rnd_fwd n=%0d got=%0d/%0d exp=%0d/%0d", n, fa1, fb1, m_fwd(m[0].rs), m_fwd(m[0].rt)); end
      total++; if ({fa0, fb0} !== 4'b0) begin bad++; $display("FAIL rnd_nofwd_sel n=%0d got=%b exp=0000", n, {fa0, fb0}); end
      total++; if (int'(c1) != mc1 || int'(c0) != mc0) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, c1, c0, mc1, mc0); end
      tick();
    end
  endtask

  initial begin
    nRST = 1'b1;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_zero_reg();
    test_mem_priority();
    test_flush();
    test_nofwd_stall();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
